control_sequencer: RTL and testbench
====================================

# control_sequencer

Multicycle control unit for the CPU core. It sits directly downstream of the instruction decoder's latched instruction word. It steps FETCH/DECODE/execute states and drives every datapath control strobe: address register, incrementer, instruction latch, memory write, register file and ALU. It replaces the hard-coded cycle counter in the `cpu` top level.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `instruction` in 32: latched instruction word from `instructionDecoder`.
- `flags` in 4: {N,Z,C,V} from the flag register.
- `c_addrout1`, `c_addrwrite`, `c_addrin1`, `c_addrin2` out 1 each: address register strobes. `in1` is the ALU bus; `in2` is the incrementer.
- `c_incrementEnable` out 1: address incrementer enable.
- `c_instrin` out 1: instruction latch enable.
- `c_memwrite` out 1: memory write.
- `c_regwrite` out 1: register file writes the write-back value to `c_rd`.
- `c_pcwrite` out 1: register file writes the incrementer bus to r15.
- `c_memtoreg` out 1: write-back source. 1 = memory data out; 0 = ALU bus.
- `c_immsel` out 1: ALU operand B source. 1 = immediate; 0 = register `c_rm`.
- `c_flagwrite` out 1: flag register update.
- `c_aluop` out 4: ALU operation, using ARM data-processing opcode numbering.
- `c_rn`, `c_rd`, `c_rm` out 4 each: register selects.
- `undef` out 1: sticky flag for an undefined instruction.
- `state` out 4: current state, for debug and the bench.

## Operation
- All outputs are registered and decoded from the next state, so outputs in cycle N always match the `state` shown in cycle N.
- Any output not listed for a state is 0.
- FETCH (0): `c_addrout1`.
- DECODE (1): `c_instrin`, `c_addrwrite`, `c_addrin2`, `c_incrementEnable`, `c_pcwrite`.
- DISPATCH (2): no strobes. Evaluates cond = `instruction[31:28]` against `flags` as sampled in this cycle.
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - AL true; 1111 false.
- Routing out of DISPATCH:
  - Condition false: go to FETCH.
  - Else class = `instruction[27:25]`:
    - 00x: DP.
    - 01x: MADDR.
    - 101: LINK if L bit [24] is set, else BRANCH.
    - 100/11x: set `undef`, go to FETCH.
- DP (3):
  - `c_aluop`=[24:21], `c_rn`=[19:16], `c_rd`=[15:12], `c_rm`=[3:0], `c_immsel`=[25], `c_flagwrite`=[20].
  - `c_regwrite`=1 unless opcode is 1000–1011 (TST/TEQ/CMP/CMN).
  - Next: FETCH.
- Load/store addressing rules: pre-indexed only. P, W and B bits are ignored (word access, no base writeback).
- MADDR (4):
  - `c_aluop` = 0100 (ADD) if U bit [23] is set, else 0010 (SUB).
  - `c_rn`=[19:16], `c_rm`=[3:0], `c_immsel`=![25].
  - `c_addrwrite`, `c_addrin1`.
  - Next: MREAD if L bit [20] is set, else MWRITE.
- MREAD (5): `c_addrout1`. Next: MWB.
- MWB (6): `c_regwrite`, `c_memtoreg`, `c_rd`=[15:12]. Next: RESTORE.
- MWRITE (7): `c_addrout1`, `c_memwrite`, `c_rd`=[15:12] (store data source). Next: RESTORE.
- RESTORE (8): `c_aluop`=1101 (MOV), `c_rm`=15, `c_addrwrite`, `c_addrin1`. Next: FETCH.
- LINK (9): `c_aluop`=1101, `c_rm`=15, `c_rd`=14, `c_regwrite`. Next: BRANCH.
- BRANCH (10):
  - `c_aluop`=0100, `c_rn`=15, `c_immsel`.
  - The immediate unit supplies sign-extended imm24<<2.
  - `c_addrwrite`, `c_addrin1`, `c_regwrite`, `c_rd`=15.
  - Next: FETCH.
- Encodings 11–15 are illegal states. They recover to FETCH on the next edge.

## Timing
- Instructions per class, FETCH to next FETCH:
  - Condition fail or undefined: 3 cycles.
  - DP: 4.
  - B: 4.
  - BL: 5.
  - STR: 6.
  - LDR: 7.
- Memory read latency is one cycle: the address is presented in FETCH/MREAD and the data is valid in the following DECODE/MWB.
- `instruction` must be stable from the edge that ends DECODE until the next FETCH.
- `reset` high at an edge, from any state:
  - `state`=FETCH and `c_addrout1`=1 in the following cycle.
  - All other outputs are 0, including `undef`.
  - An in-flight `c_memwrite` is dropped.
- `undef` stays set until `reset`.

## Structure
- Shared package `cpu_pkg` holds:
  - the state enum with the encodings above;
  - ALU opcode constants (AND=0000 … MVN=1111);
  - condition-code constants;
  - instruction-class field positions.
- One sub-module, `cond_check`: combinational, cond[3:0] + flags[3:0] -> pass.

## Test plan
- Reset, then `instruction`=0xE3A01005 (MOV r1,#5) -> states 0,1,2,3,0. DP: `c_aluop`=1101, `c_rd`=1, `c_immsel`=1, `c_regwrite`=1.
- 0xE3510000 (CMP r1,#0) -> DP with `c_regwrite`=0, `c_flagwrite`=1, `c_rn`=1.
- 0x03A01005 (MOVEQ):
  - Z=0 -> DISPATCH then FETCH, `c_regwrite` never asserted.
  - Z=1 -> DP executes.
  - Sweep all 16 cond values against the `cond_check` truth rules.
- Load/store:
  - 0xE5932004 (LDR r2,[r3,#4]) -> states 4,5,6,8: MADDR `c_aluop`=0100, `c_rn`=3, `c_immsel`=1; MWB `c_rd`=2, `c_memtoreg`=1; 7 cycles total.
  - 0xE5832004 -> MWRITE with `c_memwrite`=1, `c_rd`=2; 6 cycles.
- 0xEB000002 (BL) -> LINK (`c_rd`=14, `c_rm`=15) then BRANCH (`c_rn`=15, `c_rd`=15, `c_addrin1`=1); 5 cycles.
- Undefined and reset cases:
  - 0xE8BD0001 -> `undef`=1 after DISPATCH, back to FETCH.
  - Reset asserted in MWRITE -> `c_memwrite`=0 next cycle, `state`=0, `undef`=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU types: sequencer states, ALU opcodes, condition codes, field positions
package cpu_pkg;

   typedef enum logic [3:0] {
      ST_FETCH    = 4'd0,
      ST_DECODE   = 4'd1,
      ST_DISPATCH = 4'd2,
      ST_DP       = 4'd3,
      ST_MADDR    = 4'd4,
      ST_MREAD    = 4'd5,
      ST_MWB      = 4'd6,
      ST_MWRITE   = 4'd7,
      ST_RESTORE  = 4'd8,
      ST_LINK     = 4'd9,
      ST_BRANCH   = 4'd10
   } state_t;

   localparam logic [3:0] ALU_AND = 4'h0, ALU_EOR = 4'h1, ALU_SUB = 4'h2, ALU_RSB = 4'h3;
   localparam logic [3:0] ALU_ADD = 4'h4, ALU_ADC = 4'h5, ALU_SBC = 4'h6, ALU_RSC = 4'h7;
   localparam logic [3:0] ALU_TST = 4'h8, ALU_TEQ = 4'h9, ALU_CMP = 4'hA, ALU_CMN = 4'hB;
   localparam logic [3:0] ALU_ORR = 4'hC, ALU_MOV = 4'hD, ALU_BIC = 4'hE, ALU_MVN = 4'hF;

   localparam logic [3:0] CC_EQ = 4'h0, CC_NE = 4'h1, CC_CS = 4'h2, CC_CC = 4'h3;
   localparam logic [3:0] CC_MI = 4'h4, CC_PL = 4'h5, CC_VS = 4'h6, CC_VC = 4'h7;
   localparam logic [3:0] CC_HI = 4'h8, CC_LS = 4'h9, CC_GE = 4'hA, CC_LT = 4'hB;
   localparam logic [3:0] CC_GT = 4'hC, CC_LE = 4'hD, CC_AL = 4'hE, CC_NV = 4'hF;

   localparam int F_COND_LSB   = 28;
   localparam int F_CLASS_LSB  = 25;
   localparam int F_IMM        = 25;
   localparam int F_BR_LINK    = 24;
   localparam int F_OPCODE_LSB = 21;
   localparam int F_UP         = 23;
   localparam int F_SETFLAGS   = 20;
   localparam int F_LOAD       = 20;
   localparam int F_RN_LSB     = 16;
   localparam int F_RD_LSB     = 12;
   localparam int F_RM_LSB     = 0;

   localparam int FLAG_N = 3, FLAG_Z = 2, FLAG_C = 1, FLAG_V = 0;

   typedef struct packed {
      logic       addrout1;
      logic       addrwrite;
      logic       addrin1;
      logic       addrin2;
      logic       inc_en;
      logic       instrin;
      logic       memwrite;
      logic       regwrite;
      logic       pcwrite;
      logic       memtoreg;
      logic       immsel;
      logic       flagwrite;
      logic [3:0] aluop;
      logic [3:0] rn;
      logic [3:0] rd;
      logic [3:0] rm;
   } ctrl_t;

   // TST/TEQ/CMP/CMN only update flags and never write a register
   function automatic logic is_test_op(input logic [3:0] op);
      return op[3:2] == 2'b10;
   endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - instruction/flag inputs and datapath strobes of the control sequencer
interface control_sequencer_if;
   logic [31:0] instruction;
   logic [3:0]  flags;
   logic        c_addrout1;
   logic        c_addrwrite;
   logic        c_addrin1;
   logic        c_addrin2;
   logic        c_incrementEnable;
   logic        c_instrin;
   logic        c_memwrite;
   logic        c_regwrite;
   logic        c_pcwrite;
   logic        c_memtoreg;
   logic        c_immsel;
   logic        c_flagwrite;
   logic [3:0]  c_aluop;
   logic [3:0]  c_rn;
   logic [3:0]  c_rd;
   logic [3:0]  c_rm;
   logic        undef;
   logic [3:0]  state;

   modport master (
      input  instruction, flags,
      output c_addrout1, c_addrwrite, c_addrin1, c_addrin2, c_incrementEnable,
             c_instrin, c_memwrite, c_regwrite, c_pcwrite, c_memtoreg, c_immsel,
             c_flagwrite, c_aluop, c_rn, c_rd, c_rm, undef, state
   );

   modport slave (
      output instruction, flags,
      input  c_addrout1, c_addrwrite, c_addrin1, c_addrin2, c_incrementEnable,
             c_instrin, c_memwrite, c_regwrite, c_pcwrite, c_memtoreg, c_immsel,
             c_flagwrite, c_aluop, c_rn, c_rd, c_rm, undef, state
   );
endinterface

// File: rtl/control_sequencer_cond_check.sv
// rtl/control_sequencer_cond_check.sv - ARM condition field evaluation against {N,Z,C,V}
module cond_check
   import cpu_pkg::*;
(
   input  logic [3:0] i_cond,
   input  logic [3:0] i_flags,
   output logic       o_pass
);
   logic w_n, w_z, w_c, w_v;

   assign w_n = i_flags[FLAG_N];
   assign w_z = i_flags[FLAG_Z];
   assign w_c = i_flags[FLAG_C];
   assign w_v = i_flags[FLAG_V];

   always_comb begin
      o_pass = 1'b0;
      case (i_cond)
         CC_EQ: o_pass = w_z;
         CC_NE: o_pass = !w_z;
         CC_CS: o_pass = w_c;
         CC_CC: o_pass = !w_c;
         CC_MI: o_pass = w_n;
         CC_PL: o_pass = !w_n;
         CC_VS: o_pass = w_v;
         CC_VC: o_pass = !w_v;
         CC_HI: o_pass = w_c && !w_z;
         CC_LS: o_pass = !w_c || w_z;
         CC_GE: o_pass = (w_n == w_v);
         CC_LT: o_pass = (w_n != w_v);
         CC_GT: o_pass = !w_z && (w_n == w_v);
         CC_LE: o_pass = w_z || (w_n != w_v);
         CC_AL: o_pass = 1'b1;
         default: o_pass = 1'b0;
      endcase
   end
endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - multicycle FETCH/DECODE/execute sequencer driving all datapath strobes
module control_sequencer
   import cpu_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   control_sequencer_if.master  bus
);
   state_t      r_state;
   state_t      w_next;
   ctrl_t       r_ctrl;
   ctrl_t       w_ctrl;
   logic        r_undef;
   logic        w_set_undef;
   logic        w_pass;
   logic [31:0] w_instr;
   logic [2:0]  w_class;

   assign w_instr = bus.instruction;
   assign w_class = w_instr[F_CLASS_LSB +: 3];

   cond_check u_cond_check (
      .i_cond  (w_instr[F_COND_LSB +: 4]),
      .i_flags (bus.flags),
      .o_pass  (w_pass)
   );

   // Strobes are registered from the next-state decode so they line up with the state they belong to
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= ST_FETCH;
         r_ctrl         <= '0;
         r_ctrl.addrout1 <= 1'b1;
         r_undef        <= 1'b0;
      end else begin
         r_state <= w_next;
         r_ctrl  <= w_ctrl;
         if (w_set_undef) begin
            r_undef <= 1'b1;
         end
      end
   end

   always_comb begin
      w_next      = ST_FETCH;
      w_set_undef = 1'b0;
      case (r_state)
         ST_FETCH:    w_next = ST_DECODE;
         ST_DECODE:   w_next = ST_DISPATCH;
         ST_DISPATCH: begin
            if (w_pass) begin
               casez (w_class)
                  3'b00?:  w_next = ST_DP;
                  3'b01?:  w_next = ST_MADDR;
                  3'b101:  w_next = w_instr[F_BR_LINK] ? ST_LINK : ST_BRANCH;
                  default: w_set_undef = 1'b1;
               endcase
            end
         end
         ST_DP:       w_next = ST_FETCH;
         ST_MADDR:    w_next = w_instr[F_LOAD] ? ST_MREAD : ST_MWRITE;
         ST_MREAD:    w_next = ST_MWB;
         ST_MWB:      w_next = ST_RESTORE;
         ST_MWRITE:   w_next = ST_RESTORE;
         ST_RESTORE:  w_next = ST_FETCH;
         ST_LINK:     w_next = ST_BRANCH;
         ST_BRANCH:   w_next = ST_FETCH;
         default:     w_next = ST_FETCH;
      endcase
   end

   always_comb begin
      w_ctrl = '0;
      case (w_next)
         ST_FETCH: w_ctrl.addrout1 = 1'b1;
         ST_DECODE: begin
            w_ctrl.instrin   = 1'b1;
            w_ctrl.addrwrite = 1'b1;
            w_ctrl.addrin2   = 1'b1;
            w_ctrl.inc_en    = 1'b1;
            w_ctrl.pcwrite   = 1'b1;
         end
         ST_DP: begin
            w_ctrl.aluop     = w_instr[F_OPCODE_LSB +: 4];
            w_ctrl.rn        = w_instr[F_RN_LSB +: 4];
            w_ctrl.rd        = w_instr[F_RD_LSB +: 4];
            w_ctrl.rm        = w_instr[F_RM_LSB +: 4];
            w_ctrl.immsel    = w_instr[F_IMM];
            w_ctrl.flagwrite = w_instr[F_SETFLAGS];
            w_ctrl.regwrite  = !is_test_op(w_instr[F_OPCODE_LSB +: 4]);
         end
         ST_MADDR: begin
            // Load/store I bit is inverted: 0 selects the 12-bit immediate offset
            w_ctrl.aluop     = w_instr[F_UP] ? ALU_ADD : ALU_SUB;
            w_ctrl.rn        = w_instr[F_RN_LSB +: 4];
            w_ctrl.rm        = w_instr[F_RM_LSB +: 4];
            w_ctrl.immsel    = !w_instr[F_IMM];
            w_ctrl.addrwrite = 1'b1;
            w_ctrl.addrin1   = 1'b1;
         end
         ST_MREAD: w_ctrl.addrout1 = 1'b1;
         ST_MWB: begin
            w_ctrl.regwrite = 1'b1;
            w_ctrl.memtoreg = 1'b1;
            w_ctrl.rd       = w_instr[F_RD_LSB +: 4];
         end
         ST_MWRITE: begin
            w_ctrl.addrout1 = 1'b1;
            w_ctrl.memwrite = 1'b1;
            w_ctrl.rd       = w_instr[F_RD_LSB +: 4];
         end
         ST_RESTORE: begin
            w_ctrl.aluop     = ALU_MOV;
            w_ctrl.rm        = 4'd15;
            w_ctrl.addrwrite = 1'b1;
            w_ctrl.addrin1   = 1'b1;
         end
         ST_LINK: begin
            w_ctrl.aluop    = ALU_MOV;
            w_ctrl.rm       = 4'd15;
            w_ctrl.rd       = 4'd14;
            w_ctrl.regwrite = 1'b1;
         end
         ST_BRANCH: begin
            w_ctrl.aluop     = ALU_ADD;
            w_ctrl.rn        = 4'd15;
            w_ctrl.immsel    = 1'b1;
            w_ctrl.addrwrite = 1'b1;
            w_ctrl.addrin1   = 1'b1;
            w_ctrl.regwrite  = 1'b1;
            w_ctrl.rd        = 4'd15;
         end
         default: w_ctrl = '0;
      endcase
   end

   assign bus.c_addrout1        = r_ctrl.addrout1;
   assign bus.c_addrwrite       = r_ctrl.addrwrite;
   assign bus.c_addrin1         = r_ctrl.addrin1;
   assign bus.c_addrin2         = r_ctrl.addrin2;
   assign bus.c_incrementEnable = r_ctrl.inc_en;
   assign bus.c_instrin         = r_ctrl.instrin;
   assign bus.c_memwrite        = r_ctrl.memwrite;
   assign bus.c_regwrite        = r_ctrl.regwrite;
   assign bus.c_pcwrite         = r_ctrl.pcwrite;
   assign bus.c_memtoreg        = r_ctrl.memtoreg;
   assign bus.c_immsel          = r_ctrl.immsel;
   assign bus.c_flagwrite       = r_ctrl.flagwrite;
   assign bus.c_aluop           = r_ctrl.aluop;
   assign bus.c_rn              = r_ctrl.rn;
   assign bus.c_rd              = r_ctrl.rd;
   assign bus.c_rm              = r_ctrl.rm;
   assign bus.undef             = r_undef;
   assign bus.state             = r_state;
endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed self-checking bench for control_sequencer
module tb_control_sequencer;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_tests = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   control_sequencer_if bus ();

   control_sequencer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   typedef struct packed {
      logic [3:0] st, aluop, rn, rd, rm;
      logic addrout1, addrwrite, addrin1, addrin2, inc, instrin;
      logic regwrite, memwrite, memtoreg, immsel, flagwrite, pcwrite, undef;
   } snap_t;

   snap_t tr [0:15];
   snap_t fin;
   int    n_cyc;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic snap_t snap();
      snap_t s;
      s.st = bus.state; s.aluop = bus.c_aluop; s.rn = bus.c_rn; s.rd = bus.c_rd; s.rm = bus.c_rm;
      s.addrout1 = bus.c_addrout1; s.addrwrite = bus.c_addrwrite; s.addrin1 = bus.c_addrin1;
      s.addrin2 = bus.c_addrin2; s.inc = bus.c_incrementEnable; s.instrin = bus.c_instrin;
      s.regwrite = bus.c_regwrite; s.memwrite = bus.c_memwrite; s.memtoreg = bus.c_memtoreg;
      s.immsel = bus.c_immsel; s.flagwrite = bus.c_flagwrite; s.pcwrite = bus.c_pcwrite;
      s.undef = bus.undef;
      return s;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Runs one instruction from FETCH until the next FETCH, logging every cycle
   task automatic run(input logic [31:0] ins, input logic [3:0] fl);
      logic done;
      done = 1'b0;
      bus.instruction = ins;
      bus.flags = fl;
      tr[0] = snap();
      n_cyc = 1;
      for (int k = 0; k < 15 && !done; k++) begin
         step();
         if (bus.state == 4'd0) done = 1'b1;
         else begin
            tr[n_cyc] = snap();
            n_cyc++;
         end
      end
      fin = snap();
      check("run_done", {31'd0, done}, 32'd1);
   endtask

   function automatic logic model_pass(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cf, v, base;
      {n, z, cf, v} = f;
      case (c[3:1])
         3'd0: base = z;
         3'd1: base = cf;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = cf & ~z;
         3'd5: base = (n == v);
         3'd6: base = ~z & (n == v);
         default: base = 1'b1;
      endcase
      return c[0] ? ~base : base;
   endfunction

   initial begin
      logic any_rw;
      logic seen;
      bus.instruction = 32'hE3A01005;
      bus.flags = 4'b0000;
      step();
      step();
      reset = 1'b0;
      check("rst_state", bus.state, 0);
      check("rst_addrout1", bus.c_addrout1, 1);
      check("rst_regwrite", bus.c_regwrite, 0);
      check("rst_memwrite", bus.c_memwrite, 0);
      check("rst_undef", bus.undef, 0);

      run(32'hE3A01005, 4'b0000);
      check("mov_cycles", n_cyc, 4);
      check("mov_st1", tr[1].st, 1);
      check("mov_st2", tr[2].st, 2);
      check("mov_st3", tr[3].st, 3);
      check("dec_strobes", {tr[1].instrin, tr[1].addrwrite, tr[1].addrin2, tr[1].inc, tr[1].pcwrite}, 5'b11111);
      check("disp_quiet", {tr[2].addrout1, tr[2].regwrite, tr[2].addrwrite}, 0);
      check("mov_aluop", tr[3].aluop, 4'hD);
      check("mov_rd", tr[3].rd, 1);
      check("mov_imm", tr[3].immsel, 1);
      check("mov_rw", tr[3].regwrite, 1);
      check("mov_fw", tr[3].flagwrite, 0);

      run(32'hE3510000, 4'b0000);
      check("cmp_cycles", n_cyc, 4);
      check("cmp_aluop", tr[3].aluop, 4'hA);
      check("cmp_rw", tr[3].regwrite, 0);
      check("cmp_fw", tr[3].flagwrite, 1);
      check("cmp_rn", tr[3].rn, 1);

      run(32'h03A01005, 4'b0000);
      any_rw = 1'b0;
      for (int i = 0; i < n_cyc; i++) any_rw |= tr[i].regwrite;
      check("moveq_z0_cycles", n_cyc, 3);
      check("moveq_z0_rw", any_rw, 0);
      run(32'h03A01005, 4'b0100);
      check("moveq_z1_cycles", n_cyc, 4);
      check("moveq_z1_rw", tr[3].regwrite, 1);

      for (int c = 0; c < 16; c++) begin
         for (int f = 0; f < 16; f++) begin
            run({c[3:0], 28'h3A01005}, f[3:0]);
            check($sformatf("cond_%0h_flags_%0h", c, f), n_cyc, model_pass(c[3:0], f[3:0]) ? 4 : 3);
         end
      end

      run(32'hE5932004, 4'b0000);
      check("ldr_cycles", n_cyc, 7);
      check("ldr_states", {tr[3].st, tr[4].st, tr[5].st, tr[6].st}, 16'h4568);
      check("ldr_maddr_alu", tr[3].aluop, 4'h4);
      check("ldr_maddr_rn", tr[3].rn, 3);
      check("ldr_maddr_imm", tr[3].immsel, 1);
      check("ldr_maddr_addr", {tr[3].addrwrite, tr[3].addrin1}, 2'b11);
      check("ldr_mread", tr[4].addrout1, 1);
      check("ldr_mwb_rd", tr[5].rd, 2);
      check("ldr_mwb_m2r", {tr[5].memtoreg, tr[5].regwrite}, 2'b11);
      check("ldr_restore", {tr[6].aluop, tr[6].rm, 2'(tr[6].addrin1)}, {4'hD, 4'hF, 2'b01});

      run(32'hE5132004, 4'b0000);
      check("ldr_sub_alu", tr[3].aluop, 4'h2);

      run(32'hE5832004, 4'b0000);
      check("str_cycles", n_cyc, 6);
      check("str_states", {tr[3].st, tr[4].st, tr[5].st}, 12'h478);
      check("str_memwrite", tr[4].memwrite, 1);
      check("str_rd", tr[4].rd, 2);
      check("str_restore_mw", tr[5].memwrite, 0);

      run(32'hEB000002, 4'b0000);
      check("bl_cycles", n_cyc, 5);
      check("bl_link", {tr[3].st, tr[3].rd, tr[3].rm, tr[3].aluop}, 16'h9EFD);
      check("bl_link_rw", tr[3].regwrite, 1);
      check("bl_branch", {tr[4].st, tr[4].rn, tr[4].rd, tr[4].aluop}, 16'hAFF4);
      check("bl_branch_strb", {tr[4].addrin1, tr[4].addrwrite, tr[4].immsel, tr[4].regwrite}, 4'hF);

      run(32'hEA000002, 4'b0000);
      check("b_cycles", n_cyc, 4);
      check("b_state", tr[3].st, 10);

      check("undef_before", fin.undef, 0);
      run(32'hE8BD0001, 4'b0000);
      check("undef_cycles", n_cyc, 3);
      check("undef_dispatch", tr[2].undef, 0);
      check("undef_set", fin.undef, 1);
      run(32'hE3A01005, 4'b0000);
      check("undef_sticky", fin.undef, 1);

      bus.instruction = 32'hE5832004;
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         step();
         if (bus.state == 4'd7) seen = 1'b1;
      end
      check("reach_mwrite", seen, 1);
      check("mwrite_mw", bus.c_memwrite, 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("rstmw_memwrite", bus.c_memwrite, 0);
      check("rstmw_state", bus.state, 0);
      check("rstmw_undef", bus.undef, 0);
      check("rstmw_addrout1", bus.c_addrout1, 1);
      step();
      check("post_rst_decode", bus.state, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
